// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline PC sequencing logic.
package pipe_ctrl_pkg;

  // Controller states; the encoding is also what the debug state port shows.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_PEND  = 2'b10,
    ST_HALT  = 2'b11
  } ctrlStateT;

  // PC mux selects; 2'b11 is never driven.
  localparam logic [1:0] SEL_NEXT   = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the controller performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones, clear synchronously.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_flow_controller.sv
// PC sequencing controller: decides each cycle whether the PC advances,
// holds or is redirected, drives IF/ID and ID/EX squash/stall controls,
// and keeps saturating stall and redirect counters.
module pc_flow_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_id,
  input  logic             branch_ex,
  input  logic             taken_ex,
  input  logic             load_use,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_enable,
  output logic [1:0]       pc_sel,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             stall_if_id,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       dbgState
);

  // Bubble counter holds 1..3, so two bits are enough.
  localparam logic [1:0] BUBBLE_LOAD = 2'(REDIRECT_BUBBLES);

  ctrlStateT  state, nextState;
  logic [1:0] bubbleCnt, nextBubble;
  logic [1:0] pendSel, nextPendSel;
  logic [1:0] redirSel;
  logic       branchTaken;
  logic       redirectInc;
  logic       stallInc;

  // taken_ex only means something when a branch is actually in EX.
  assign branchTaken = branch_ex & taken_ex;
  assign dbgState    = state;

  // State, bubble counter and pending select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      bubbleCnt <= 2'd0;
      pendSel   <= SEL_NEXT;
    end else begin
      state     <= nextState;
      bubbleCnt <= nextBubble;
      pendSel   <= nextPendSel;
    end
  end

  // Mealy next-state and output decode; everything is quiet while rst is high.
  always_comb begin
    pc_enable   = 1'b0;
    pc_sel      = SEL_NEXT;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stall_if_id = 1'b0;
    halted      = 1'b0;
    redirectInc = 1'b0;
    redirSel    = branchTaken ? SEL_BRANCH : SEL_JUMP;
    nextState   = state;
    nextBubble  = bubbleCnt;
    nextPendSel = pendSel;
    if (!rst) begin
      unique case (state)
        ST_RUN: begin
          if (halt_req) begin
            nextState = ST_HALT;
          end else if (branchTaken || jump_id) begin
            // A taken branch kills the ID/EX slot; a jump only kills IF/ID.
            flush_if_id = !branchTaken || !mem_busy;
            flush_id_ex = branchTaken;
            if (!mem_busy) begin
              pc_enable   = 1'b1;
              pc_sel      = redirSel;
              redirectInc = 1'b1;
              nextBubble  = BUBBLE_LOAD;
              nextState   = ST_FLUSH;
            end else begin
              nextPendSel = redirSel;
              nextState   = ST_PEND;
            end
          end else if (load_use) begin
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (mem_busy) begin
            stall_if_id = 1'b1;
          end else begin
            pc_enable = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (halt_req) begin
            nextState = ST_HALT;
          end else begin
            // Squashed slots: decode-side hazards and redirects are ignored.
            flush_if_id = 1'b1;
            pc_enable   = !mem_busy;
            if (!mem_busy) begin
              nextBubble = bubbleCnt - 2'd1;
              if (bubbleCnt == 2'd1) begin
                nextState = ST_RUN;
              end
            end
          end
        end
        ST_PEND: begin
          if (halt_req) begin
            nextPendSel = SEL_NEXT;
            nextState   = ST_HALT;
          end else if (!mem_busy) begin
            pc_enable   = 1'b1;
            pc_sel      = pendSel;
            flush_if_id = 1'b1;
            redirectInc = 1'b1;
            nextPendSel = SEL_NEXT;
            nextBubble  = BUBBLE_LOAD;
            nextState   = ST_FLUSH;
          end else begin
            stall_if_id = 1'b1;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          nextState = ST_RUN;
        end
      endcase
    end
  end

  // Stall cycles exclude reset and the halted state.
  assign stallInc = !rst && (state != ST_HALT) && !pc_enable;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stallInc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirectCnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirectInc),
    .count (redirect_cnt)
  );

endmodule
